// File: rtl/unified_mem_arbiter_if.sv
// Bundle between the arbiter, the IF/MEM requesters and the shared RAM.
// The arbiter takes the master side; requesters plus RAM model take the slave side.
interface unified_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] if_rdata;
    logic [DW-1:0] mem_rdata;
    logic          pipe_stall;
    logic          bus_err;
    logic          ram_req;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          ram_ack;

    modport master (
        input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata,
        input  ram_rdata, ram_ack,
        output if_rdata, mem_rdata, pipe_stall, bus_err,
        output ram_req, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata,
        output ram_rdata, ram_ack,
        input  if_rdata, mem_rdata, pipe_stall, bus_err,
        input  ram_req, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Serialises IF and MEM accesses onto one single-ported RAM, MEM first,
// freezing the pipeline until both are done; watchdog abandons dead accesses.
module unified_mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input logic                  clk,
    input logic                  rst_n,
    unified_mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEM_ACC = 2'd1,
        IF_ACC  = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          if_done_q, if_done_d;
    logic          mem_done_q, mem_done_d;
    logic [7:0]    wdog_q, wdog_d;
    logic          bus_err_q, bus_err_d;
    logic          ram_req_q, ram_req_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] mem_rdata_q, mem_rdata_d;

    logic          mem_pend;
    logic          if_pend;
    logic          fin;
    logic [DW-1:0] fin_data;

    assign mem_pend = (bus.mem_rd | bus.mem_wr) & ~mem_done_q;
    assign if_pend  = bus.if_req & ~if_done_q;
    // An expired watchdog completes the access like an ack carrying zero.
    assign fin      = bus.ram_ack | (wdog_q == TMO_LAST);
    assign fin_data = bus.ram_ack ? bus.ram_rdata : '0;

    always_comb begin
        state_d     = state_q;
        if_done_d   = if_done_q;
        mem_done_d  = mem_done_q;
        wdog_d      = wdog_q;
        bus_err_d   = bus_err_q;
        ram_req_d   = ram_req_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;

        if (!(if_pend | mem_pend)) begin
            if_done_d  = 1'b0;
            mem_done_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (mem_pend) begin
                    state_d     = MEM_ACC;
                    ram_req_d   = 1'b1;
                    ram_we_d    = bus.mem_wr;
                    ram_addr_d  = bus.mem_addr;
                    ram_wdata_d = bus.mem_wdata;
                    wdog_d      = '0;
                end else if (if_pend) begin
                    state_d    = IF_ACC;
                    ram_req_d  = 1'b1;
                    ram_we_d   = 1'b0;
                    ram_addr_d = bus.if_addr;
                    wdog_d     = '0;
                end
            end
            MEM_ACC: begin
                if (fin) begin
                    if (!ram_we_q) mem_rdata_d = fin_data;
                    mem_done_d = 1'b1;
                    if (!bus.ram_ack) bus_err_d = 1'b1;
                    if (if_pend) begin
                        state_d    = IF_ACC;
                        ram_we_d   = 1'b0;
                        ram_addr_d = bus.if_addr;
                        wdog_d     = '0;
                    end else begin
                        state_d   = IDLE;
                        ram_req_d = 1'b0;
                    end
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            IF_ACC: begin
                if (fin) begin
                    if_rdata_d = fin_data;
                    if_done_d  = 1'b1;
                    if (!bus.ram_ack) bus_err_d = 1'b1;
                    state_d   = IDLE;
                    ram_req_d = 1'b0;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                ram_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            wdog_q      <= '0;
            bus_err_q   <= 1'b0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            wdog_q      <= wdog_d;
            bus_err_q   <= bus_err_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // Stall is gated by reset so an asserted reset releases the core at once.
    assign bus.pipe_stall = rst_n & (if_pend | mem_pend);
    assign bus.bus_err    = bus_err_q;
    assign bus.ram_req    = ram_req_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wdata  = ram_wdata_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.mem_rdata  = mem_rdata_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: RAM responder records accesses,
// tests compare them against a queue of expected accesses.
module tb_unified_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          len;
        bit          stable;
        int          start;
    } obs_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   cyc;
    int   ack_wait;
    bit   stale_ack;
    bit   in_acc;
    bit   ack_given;
    int   wcnt;
    obs_t cur;

    exp_t        exp_q[$];
    obs_t        obs_q[$];
    logic [31:0] rsp_q[$];

    unified_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    unified_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // RAM model: acks after ack_wait extra cycles (-1 = never), logs each access.
    always @(negedge clk) begin
        bus.ram_ack   = 1'b0;
        bus.ram_rdata = '0;
        if (!rst_n) begin
            in_acc    = 1'b0;
            ack_given = 1'b0;
        end else if (bus.ram_req) begin
            if (!in_acc || ack_given) begin
                cur.addr   = bus.ram_addr;
                cur.we     = bus.ram_we;
                cur.wdata  = bus.ram_wdata;
                cur.len    = 0;
                cur.stable = 1'b1;
                cur.start  = cyc;
                in_acc     = 1'b1;
                ack_given  = 1'b0;
                wcnt       = 0;
            end else if (bus.ram_addr !== cur.addr || bus.ram_we !== cur.we ||
                         bus.ram_wdata !== cur.wdata) begin
                cur.stable = 1'b0;
            end
            cur.len++;
            if (ack_wait >= 0 && wcnt == ack_wait) begin
                bus.ram_ack   = 1'b1;
                bus.ram_rdata = (rsp_q.size() > 0) ? rsp_q.pop_front() : '0;
                ack_given     = 1'b1;
                obs_q.push_back(cur);
            end else begin
                wcnt++;
            end
        end else begin
            if (in_acc && !ack_given) obs_q.push_back(cur);
            in_acc    = 1'b0;
            ack_given = 1'b0;
            if (stale_ack) begin
                bus.ram_ack   = 1'b1;
                bus.ram_rdata = 32'hBAD0BAD0;
            end
        end
    end

    task automatic idle_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        stale_ack = 1'b0;
        ack_wait  = 0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ram_req !== 1'b0 || bus.ram_we !== 1'b0 || bus.ram_addr !== '0) begin
            failures++;
            $display("FAIL reset_ram got req=%b we=%b addr=%h want 0/0/0",
                     bus.ram_req, bus.ram_we, bus.ram_addr);
        end
        checks++;
        if (bus.pipe_stall !== 1'b0 || bus.bus_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got stall=%b err=%b want 0/0",
                     bus.pipe_stall, bus.bus_err);
        end
        checks++;
        if (bus.if_rdata !== '0 || bus.mem_rdata !== '0) begin
            failures++;
            $display("FAIL reset_rdata got if=%h mem=%h want 0/0",
                     bus.if_rdata, bus.mem_rdata);
        end
    endtask

    task automatic test_if_fetch();
        int   stall;
        obs_t o;
        exp_t e;
        exp_q.push_back('{32'h100, 1'b0, 32'h0});
        rsp_q.push_back(32'h20080005);
        ack_wait = 0;
        @(posedge clk);
        #1;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        stall = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.pipe_stall) stall++;
            else break;
        end
        @(posedge clk);
        #1 idle_inputs();
        checks++;
        if (stall !== 2) begin
            failures++;
            $display("FAIL if_stall got %0d want 2", stall);
        end
        checks++;
        if (bus.if_rdata !== 32'h20080005) begin
            failures++;
            $display("FAIL if_rdata got %h want 20080005", bus.if_rdata);
        end
        e = exp_q.pop_front();
        checks++;
        if (obs_q.size() != 1) begin
            failures++;
            $display("FAIL if_count got %0d want 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            if (o.addr !== e.addr || o.we !== e.we || o.len != 1) begin
                failures++;
                $display("FAIL if_access got addr=%h we=%b len=%0d want %h/%b/1",
                         o.addr, o.we, o.len, e.addr, e.we);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_load_fetch();
        int   stall;
        obs_t o0;
        obs_t o1;
        exp_t e0;
        exp_t e1;
        exp_q.push_back('{32'h40, 1'b0, 32'h0});
        exp_q.push_back('{32'h104, 1'b0, 32'h0});
        rsp_q.push_back(32'hDEADBEEF);
        rsp_q.push_back(32'h8C090000);
        ack_wait = 0;
        @(posedge clk);
        #1;
        bus.mem_rd   = 1'b1;
        bus.mem_addr = 32'h40;
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h104;
        stall = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.pipe_stall) stall++;
            else break;
        end
        @(posedge clk);
        #1 idle_inputs();
        checks++;
        if (stall !== 3) begin
            failures++;
            $display("FAIL lf_stall got %0d want 3", stall);
        end
        checks++;
        if (bus.mem_rdata !== 32'hDEADBEEF || bus.if_rdata !== 32'h8C090000) begin
            failures++;
            $display("FAIL lf_rdata got mem=%h if=%h want deadbeef/8c090000",
                     bus.mem_rdata, bus.if_rdata);
        end
        e0 = exp_q.pop_front();
        e1 = exp_q.pop_front();
        checks++;
        if (obs_q.size() != 2) begin
            failures++;
            $display("FAIL lf_count got %0d want 2", obs_q.size());
        end else begin
            o0 = obs_q.pop_front();
            o1 = obs_q.pop_front();
            if (o0.addr !== e0.addr || o1.addr !== e1.addr || o0.we !== e0.we ||
                o1.we !== e1.we || o1.start != o0.start + o0.len) begin
                failures++;
                $display("FAIL lf_seq got %h,%h gap=%0d want %h,%h gap=0",
                         o0.addr, o1.addr, o1.start - o0.start - o0.len,
                         e0.addr, e1.addr);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_store();
        int   stall;
        obs_t o;
        exp_t e;
        exp_q.push_back('{32'h44, 1'b1, 32'h12345678});
        rsp_q.push_back(32'hFFFF0000);
        ack_wait = 3;
        @(posedge clk);
        #1;
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = 32'h44;
        bus.mem_wdata = 32'h12345678;
        stall = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.pipe_stall) stall++;
            else break;
        end
        @(posedge clk);
        #1 idle_inputs();
        checks++;
        if (stall !== 5) begin
            failures++;
            $display("FAIL st_stall got %0d want 5", stall);
        end
        checks++;
        if (bus.mem_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL st_rdata got %h want deadbeef", bus.mem_rdata);
        end
        e = exp_q.pop_front();
        checks++;
        if (obs_q.size() != 1) begin
            failures++;
            $display("FAIL st_count got %0d want 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            if (o.addr !== e.addr || o.we !== e.we || o.wdata !== e.wdata ||
                o.len != 4 || !o.stable) begin
                failures++;
                $display("FAIL st_access got %h/%b/%h len=%0d stable=%0d want %h/%b/%h len=4 stable=1",
                         o.addr, o.we, o.wdata, o.len, o.stable, e.addr, e.we, e.wdata);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_rd_wr_both();
        int   stall;
        obs_t o;
        exp_t e;
        exp_q.push_back('{32'h4C, 1'b1, 32'hCAFEF00D});
        rsp_q.push_back(32'h11111111);
        ack_wait = 0;
        @(posedge clk);
        #1;
        bus.mem_rd    = 1'b1;
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = 32'h4C;
        bus.mem_wdata = 32'hCAFEF00D;
        stall = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.pipe_stall) stall++;
            else break;
        end
        @(posedge clk);
        #1 idle_inputs();
        checks++;
        if (stall !== 2 || bus.mem_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL rw_step got stall=%0d rdata=%h want 2/deadbeef",
                     stall, bus.mem_rdata);
        end
        e = exp_q.pop_front();
        checks++;
        if (obs_q.size() != 1) begin
            failures++;
            $display("FAIL rw_count got %0d want 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            if (o.we !== e.we || o.addr !== e.addr || o.wdata !== e.wdata) begin
                failures++;
                $display("FAIL rw_access got %h/%b/%h want %h/%b/%h",
                         o.addr, o.we, o.wdata, e.addr, e.we, e.wdata);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_dead_memory();
        int   stall;
        obs_t o;
        exp_t e;
        exp_q.push_back('{32'h200, 1'b0, 32'h0});
        ack_wait = -1;
        @(posedge clk);
        #1;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h200;
        stall = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.pipe_stall) stall++;
            else break;
        end
        @(posedge clk);
        #1 idle_inputs();
        checks++;
        if (stall !== 16) begin
            failures++;
            $display("FAIL dead_stall got %0d want 16", stall);
        end
        checks++;
        if (bus.if_rdata !== '0 || bus.bus_err !== 1'b1) begin
            failures++;
            $display("FAIL dead_result got rdata=%h err=%b want 0/1",
                     bus.if_rdata, bus.bus_err);
        end
        e = exp_q.pop_front();
        checks++;
        if (obs_q.size() != 1) begin
            failures++;
            $display("FAIL dead_count got %0d want 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            if (o.addr !== e.addr || o.len != 15) begin
                failures++;
                $display("FAIL dead_access got addr=%h len=%0d want %h/15",
                         o.addr, o.len, e.addr);
            end
        end
        obs_q.delete();
        // A healthy fetch afterwards must leave the sticky error set.
        ack_wait = 0;
        rsp_q.push_back(32'h00000013);
        @(posedge clk);
        #1;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h204;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.pipe_stall) break;
        end
        @(posedge clk);
        #1 idle_inputs();
        checks++;
        if (bus.bus_err !== 1'b1 || bus.if_rdata !== 32'h00000013) begin
            failures++;
            $display("FAIL dead_sticky got err=%b rdata=%h want 1/00000013",
                     bus.bus_err, bus.if_rdata);
        end
        obs_q.delete();
    endtask

    task automatic test_reset_mid_access();
        int   stall;
        obs_t o;
        exp_t e;
        ack_wait = -1;
        @(posedge clk);
        #1;
        bus.mem_rd   = 1'b1;
        bus.mem_addr = 32'h48;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.ram_req !== 1'b1) begin
            failures++;
            $display("FAIL rm_inflight got req=%b want 1", bus.ram_req);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.ram_req !== 1'b0 || bus.pipe_stall !== 1'b0 || bus.bus_err !== 1'b0) begin
            failures++;
            $display("FAIL rm_async got req=%b stall=%b err=%b want 0/0/0",
                     bus.ram_req, bus.pipe_stall, bus.bus_err);
        end
        idle_inputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        stale_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1 stale_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ram_req !== 1'b0 || bus.mem_rdata !== '0 || bus.if_rdata !== '0) begin
            failures++;
            $display("FAIL rm_stale got req=%b mem=%h if=%h want 0/0/0",
                     bus.ram_req, bus.mem_rdata, bus.if_rdata);
        end
        obs_q.delete();
        exp_q.push_back('{32'h48, 1'b0, 32'h0});
        rsp_q.push_back(32'h55AA55AA);
        ack_wait = 0;
        @(posedge clk);
        #1;
        bus.mem_rd   = 1'b1;
        bus.mem_addr = 32'h48;
        stall = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.pipe_stall) stall++;
            else break;
        end
        @(posedge clk);
        #1 idle_inputs();
        checks++;
        if (stall !== 2 || bus.mem_rdata !== 32'h55AA55AA) begin
            failures++;
            $display("FAIL rm_fresh got stall=%0d rdata=%h want 2/55aa55aa",
                     stall, bus.mem_rdata);
        end
        e = exp_q.pop_front();
        checks++;
        if (obs_q.size() != 1) begin
            failures++;
            $display("FAIL rm_count got %0d want 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            if (o.addr !== e.addr || o.we !== e.we) begin
                failures++;
                $display("FAIL rm_access got %h/%b want %h/%b",
                         o.addr, o.we, e.addr, e.we);
            end
        end
        obs_q.delete();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        in_acc    = 1'b0;
        ack_given = 1'b0;
        wcnt      = 0;
        test_reset();
        test_if_fetch();
        test_load_fetch();
        test_store();
        test_rd_wr_both();
        test_dead_memory();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-ported instruction/data RAM between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline.
- Serialises the two accesses within each pipeline step, MEM first.
- Holds returned data until both are complete.
- Drives pipe_stall, which the top level ORs into the stall logic as a global freeze of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Includes an ack watchdog so a dead memory cannot hang the core.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 15, maximum cycles ram_req may stay high without ram_ack before the access is abandoned (legal range 1..255)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
if_req  input  1  IF stage wants an instruction this pipeline step
if_addr  input  AW  fetch address (PC)
mem_rd  input  1  MEM stage load
mem_wr  input  1  MEM stage store
mem_addr  input  AW  load/store address
mem_wdata  input  DW  store data
if_rdata  output  DW  fetched instruction, registered
mem_rdata  output  DW  load data, registered
pipe_stall  output  1  freeze whole pipeline this cycle
bus_err  output  1  sticky, watchdog expired at least once
ram_req  output  1  access request, registered
ram_we  output  1  write enable, registered
ram_addr  output  AW  registered
ram_wdata  output  DW  registered
ram_rdata  input  DW  read data, valid with ram_ack
ram_ack  input  1  one-cycle completion pulse, sampled only while ram_req=1

Behaviour:
- Reset: all outputs 0, state IDLE, if_done=mem_done=0, watchdog=0. Reset asserted mid-access drops ram_req immediately (asynchronous); that access is discarded.
- Pending terms:
  - mem_pend = (mem_rd|mem_wr) & ~mem_done
  - if_pend = if_req & ~if_done
- pipe_stall = if_pend | mem_pend. Combinational from inputs and done flags.
- Advance: any clock edge with pipe_stall=0 clears if_done and mem_done. This is the edge where the pipeline samples if_rdata/mem_rdata.
- FSM states: IDLE, MEM_ACC, IF_ACC.
- IDLE:
  - mem_pend -> MEM_ACC. Load ram_addr=mem_addr, ram_we=mem_wr, ram_wdata=mem_wdata, ram_req=1.
  - Else if_pend -> IF_ACC. Load ram_addr=if_addr, ram_we=0, ram_req=1.
  - Else stay in IDLE.
  - MEM always wins over IF because it belongs to the older instruction.
- mem_rd & mem_wr both 1: treated as a store; the read is ignored.
- MEM_ACC on ram_ack:
  - Load: capture mem_rdata=ram_rdata. Store: mem_rdata holds its previous value.
  - Set mem_done.
  - If if_pend: go directly to IF_ACC, loading IF address and ram_req=1 in the same edge, with no idle bubble.
  - Otherwise: ram_req=0, go to IDLE.
- IF_ACC on ram_ack: capture if_rdata=ram_rdata, set if_done, ram_req=0, go to IDLE.
- While ram_req=1, ram_addr, ram_we and ram_wdata are stable. Requester inputs are not resampled mid-access.
- Minimum latency: ack in the first ram_req cycle.
  - A single IF-only step stalls 2 cycles.
  - A MEM+IF step stalls 3 cycles.
- Watchdog:
  - 8-bit counter, cleared on entry to MEM_ACC/IF_ACC, increments each ACC cycle without ack.
  - On reaching TIMEOUT: treat as a completion with data 0 (rdata=0), set done for that requester, set bus_err, follow the normal ack transitions.
  - bus_err clears only on reset.
- Requester withdraws its request while its access is in flight: the access still completes and the done flag sets. The done flag is irrelevant to pipe_stall and clears at the next advance.
- Done flags for a requester not requesting stay 0.
- ram_ack while ram_req=0 is ignored.

Test Plan:
- Reset, then if_req=1, if_addr=0x100, ack with 0x20080005 in the first req cycle. Required: ram_req high exactly 1 cycle with ram_addr=0x100, ram_we=0; pipe_stall high 2 cycles; if_rdata=0x20080005 on the advance edge.
- Load plus fetch in the same step: mem_rd=1, mem_addr=0x40, if_addr=0x104, RAM returns 0xDEADBEEF then 0x8C090000. Required: ram_addr sequence 0x40 then 0x104 back-to-back with no idle cycle; mem_rdata=0xDEADBEEF; if_rdata=0x8C090000; pipe_stall high 3 cycles.
- Store: mem_wr=1, mem_addr=0x44, mem_wdata=0x12345678, ack after 3 wait cycles. Required: ram_we=1, ram_wdata=0x12345678 held stable for 4 cycles; mem_rdata unchanged.
- Dead memory (ram_ack never) with TIMEOUT=15 on an IF access. Required: ram_req drops after 15 cycles; if_rdata=0; bus_err=1 and remains 1; pipeline then advances.
- Reset pulse in the middle of a MEM_ACC wait. Required: ram_req=0 and pipe_stall=0 asynchronously; after release, a fresh request starts in IDLE and the stale ack is ignored.
- mem_rd=mem_wr=1. Required: a single access with ram_we=1.
